// File: rtl/sram_burst_iface_if.sv
// Bus bundle between a burst requester/SRAM model and sram_burst_iface.
// The master side plays both requester and SRAM (it drives start/i_w_data
// and also returns r_data); the slave side is the burst adapter itself.
interface sram_burst_iface_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int WAIT_W    = 4
);
  localparam int BL_W = $clog2(MAX_BURST);

  // request side
  logic              start;
  logic              writemode;
  logic [ADDR_W-1:0] i_address;
  logic [BL_W-1:0]   burst_len;
  logic [WAIT_W-1:0] wait_cycles;
  logic [DATA_W-1:0] i_w_data;
  logic              w_take;
  logic [DATA_W-1:0] i_r_data;
  logic              r_valid;
  logic              busy;
  logic              io_done;
  logic              wrap_err;
  // SRAM side
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;

  modport master (
    output start, writemode, i_address, burst_len, wait_cycles, i_w_data, r_data,
    input  w_take, i_r_data, r_valid, busy, io_done, wrap_err,
           read_enable, write_enable, address, w_data
  );

  modport slave (
    input  start, writemode, i_address, burst_len, wait_cycles, i_w_data, r_data,
    output w_take, i_r_data, r_valid, busy, io_done, wrap_err,
           read_enable, write_enable, address, w_data
  );
endinterface

// File: rtl/sram_burst_iface.sv
// Burst SRAM adapter: 1..MAX_BURST beats, auto-incrementing address,
// programmable wait states per beat, write pull strobe, read valid strobe.
module sram_burst_iface #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int WAIT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  sram_burst_iface_if.slave   bus
);
  localparam int BL_W = $clog2(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              mode_q;     // 1 = write burst
  logic [BL_W-1:0]   len_q;      // beats minus 1
  logic [WAIT_W-1:0] wlat_q;     // wait states per beat
  logic [BL_W:0]     beat_q;     // current beat index
  logic [WAIT_W-1:0] wcnt_q;     // cycle within current beat
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              ren_q;
  logic              wen_q;
  logic              busy_q;
  logic              done_q;
  logic              wrap_q;

  logic              beat_end;   // last cycle of the current beat
  logic              last_beat;  // current beat is the final one
  logic [ADDR_W-1:0] addr_d;

  assign beat_end  = (wcnt_q == wlat_q);
  assign last_beat = (beat_q == {1'b0, len_q});
  assign addr_d    = addr_q + ADDR_W'(1);

  // Pull strobe is combinational so the producer sees it in the very cycle
  // the word is captured; held low while reset is asserted.
  assign bus.w_take = ~rst & (
      ((state_q == IDLE)   & bus.start & bus.writemode) |
      ((state_q == ACCESS) & mode_q & beat_end & ~last_beat));

  assign bus.i_r_data     = rdata_q;
  assign bus.r_valid      = rvalid_q;
  assign bus.busy         = busy_q;
  assign bus.io_done      = done_q;
  assign bus.wrap_err     = wrap_q;
  assign bus.read_enable  = ren_q;
  assign bus.write_enable = wen_q;
  assign bus.address      = addr_q;
  assign bus.w_data       = wdata_q;

  // Burst FSM with all SRAM-facing and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      len_q    <= '0;
      wlat_q   <= '0;
      beat_q   <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.writemode;
            addr_q  <= bus.i_address;
            len_q   <= bus.burst_len;
            wlat_q  <= bus.wait_cycles;
            beat_q  <= '0;
            wcnt_q  <= '0;
            wrap_q  <= 1'b0;
            ren_q   <= ~bus.writemode;
            wen_q   <= bus.writemode;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
            if (bus.writemode) wdata_q <= bus.i_w_data;
          end
        end
        ACCESS: begin
          if (beat_end) begin
            wcnt_q <= '0;
            if (!mode_q) begin
              rdata_q  <= bus.r_data;
              rvalid_q <= 1'b1;
            end
            if (last_beat) begin
              ren_q   <= 1'b0;
              wen_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= addr_d;
              // stepping past all-ones flags the wrap but the burst goes on
              if (&addr_q) wrap_q <= 1'b1;
              if (mode_q) wdata_q <= bus.i_w_data;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
